// File: rtl/shared_vc_credit_pool.sv
// Shared virtual-channel credit pool.
// Several router ports draw single credits from one common pool. Each port
// may hold at most max_per_port credits at once. A port gives a credit back
// when the downstream slot drains. Grants are picked by round-robin or by
// fixed priority. All outputs come straight from registers.
module shared_vc_credit_pool #(
  parameter int num_ports          = 5,
  parameter int shared_buffer_size = 8,
  parameter int max_per_port       = 4,
  parameter int arb_policy         = 0,
  localparam int cnt_width         = $clog2(shared_buffer_size + 1),
  localparam int pcnt_width        = $clog2(max_per_port + 1),
  localparam int rr_width          = (num_ports > 1) ? $clog2(num_ports) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [num_ports-1:0] alloc_req_ip,
  input  logic [num_ports-1:0] credit_for_shared_in,
  output logic [num_ports-1:0] alloc_gnt_ip,
  output logic [num_ports-1:0] ready_for_allocation_out,
  output logic [num_ports-1:0] shared_vc_out,
  output logic [cnt_width-1:0] free_count,
  output logic                 error
);

  logic [cnt_width-1:0]  r_free_count;
  logic [pcnt_width-1:0] r_out_cnt [num_ports];
  logic [rr_width-1:0]   r_rr_ptr;
  logic [num_ports-1:0]  r_gnt;
  logic [num_ports-1:0]  r_ready;
  logic [num_ports-1:0]  r_svc;
  logic                  r_error;

  logic [num_ports-1:0]  w_elig;
  logic [num_ports-1:0]  w_gnt_sel;
  logic                  w_found;
  int                    w_gnt_idx;
  int                    w_scan;
  logic [rr_width-1:0]   w_rr_next;
  logic [num_ports-1:0]  w_ret_valid;
  logic [num_ports-1:0]  w_ret_bad;
  logic [cnt_width-1:0]  w_nret;
  logic [cnt_width-1:0]  w_free_next;
  logic [pcnt_width-1:0] w_out_next [num_ports];
  logic [num_ports-1:0]  w_ready_next;
  logic [num_ports-1:0]  w_svc_next;
  logic [31:0]           w_sum;
  logic                  w_error_next;

  assign alloc_gnt_ip             = r_gnt;
  assign ready_for_allocation_out = r_ready;
  assign shared_vc_out            = r_svc;
  assign free_count               = r_free_count;
  assign error                    = r_error;

  // A port is eligible when it requests, the pool has a credit and the port is below its cap.
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < num_ports; p++) begin
      w_elig[p] = alloc_req_ip[p] && (r_free_count != '0) &&
                  (32'(r_out_cnt[p]) < 32'(max_per_port));
    end
  end

  // Pick at most one eligible port: scan from rr_ptr with wrap, or from port 0 for fixed priority.
  always_comb begin
    w_gnt_sel = '0;
    w_found   = 1'b0;
    w_gnt_idx = 0;
    w_scan    = 0;
    for (int i = 0; i < num_ports; i++) begin
      if (arb_policy == 1) begin
        w_scan = i;
      end else begin
        w_scan = int'(r_rr_ptr) + i;
        if (w_scan >= num_ports) begin
          w_scan = w_scan - num_ports;
        end else begin
          w_scan = w_scan;
        end
      end
      if (!w_found && w_elig[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan;
      end else begin
        w_found   = w_found;
      end
    end
    if (w_found) begin
      w_gnt_sel[w_gnt_idx] = 1'b1;
    end else begin
      w_gnt_sel = '0;
    end
    if (arb_policy == 1) begin
      w_rr_next = '0;
    end else if (w_found) begin
      w_rr_next = rr_width'((w_gnt_idx + 1) % num_ports);
    end else begin
      w_rr_next = r_rr_ptr;
    end
  end

  // Next counter values: valid returns free credits, returns with nothing outstanding are flagged.
  always_comb begin
    w_ret_valid  = '0;
    w_ret_bad    = '0;
    w_nret       = '0;
    w_ready_next = '0;
    w_svc_next   = '0;
    w_sum        = 32'(r_free_count);
    for (int p = 0; p < num_ports; p++) begin
      w_ret_valid[p] = credit_for_shared_in[p] && (r_out_cnt[p] != '0);
      w_ret_bad[p]   = credit_for_shared_in[p] && (r_out_cnt[p] == '0);
      w_nret         = w_nret + cnt_width'(w_ret_valid[p]);
      w_out_next[p]  = r_out_cnt[p] + pcnt_width'(w_gnt_sel[p]) - pcnt_width'(w_ret_valid[p]);
      w_sum          = w_sum + 32'(r_out_cnt[p]);
    end
    // Credits returned this cycle are only added after the grant decision.
    w_free_next = r_free_count - cnt_width'(w_found) + w_nret;
    for (int p = 0; p < num_ports; p++) begin
      w_ready_next[p] = (w_free_next != '0) && (32'(w_out_next[p]) < 32'(max_per_port));
      w_svc_next[p]   = (w_out_next[p] != '0);
    end
    // Sticky error on a bad return or a broken pool conservation sum.
    w_error_next = r_error || (w_ret_bad != '0) || (w_sum != 32'(shared_buffer_size));
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_free_count <= cnt_width'(shared_buffer_size);
      for (int p = 0; p < num_ports; p++) begin
        r_out_cnt[p] <= '0;
      end
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_ready  <= '1;
      r_svc    <= '0;
      r_error  <= 1'b0;
    end else begin
      r_free_count <= w_free_next;
      for (int p = 0; p < num_ports; p++) begin
        r_out_cnt[p] <= w_out_next[p];
      end
      r_rr_ptr <= w_rr_next;
      r_gnt    <= w_gnt_sel;
      r_ready  <= w_ready_next;
      r_svc    <= w_svc_next;
      r_error  <= w_error_next;
    end
  end

endmodule

// File: tb/tb_shared_vc_credit_pool.sv
// Directed bench for shared_vc_credit_pool: a round-robin instance and a
// fixed-priority instance, each test task checking its own expectations.
module tb_shared_vc_credit_pool;

  logic       clk;
  logic       rst;
  logic [4:0] req, cred, gnt, rdy, svc;
  logic [3:0] fc;
  logic       err;

  logic       fp_rst;
  logic [4:0] fp_req, fp_cred, fp_gnt, fp_rdy, fp_svc;
  logic [3:0] fp_fc;
  logic       fp_err;

  int total = 0;
  int bad   = 0;

  shared_vc_credit_pool u_rr (
    .clk(clk), .reset(rst), .alloc_req_ip(req), .credit_for_shared_in(cred),
    .alloc_gnt_ip(gnt), .ready_for_allocation_out(rdy), .shared_vc_out(svc),
    .free_count(fc), .error(err)
  );

  shared_vc_credit_pool #(.arb_policy(1)) u_fp (
    .clk(clk), .reset(fp_rst), .alloc_req_ip(fp_req), .credit_for_shared_in(fp_cred),
    .alloc_gnt_ip(fp_gnt), .ready_for_allocation_out(fp_rdy), .shared_vc_out(fp_svc),
    .free_count(fp_fc), .error(fp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 5'b11111; cred = 5'b10101;
    tick();
    total++; if (fc !== 4'd8)       begin bad++; $display("FAIL reset_free got=%0d exp=8", fc); end
    total++; if (gnt !== 5'b00000)  begin bad++; $display("FAIL reset_gnt got=%b exp=00000", gnt); end
    total++; if (rdy !== 5'b11111)  begin bad++; $display("FAIL reset_ready got=%b exp=11111", rdy); end
    total++; if (svc !== 5'b00000)  begin bad++; $display("FAIL reset_svc got=%b exp=00000", svc); end
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    req = 5'b0; cred = 5'b0; rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int         exp_p [8] = '{0, 1, 2, 3, 4, 0, 1, 2};
    logic [4:0] e;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 5'b11111;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = 5'b00001 << exp_p[k];
      total++; if (gnt !== e)                 begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt, e); end
      total++; if (fc !== 4'(7 - k))          begin bad++; $display("FAIL rr_free[%0d] got=%0d exp=%0d", k, fc, 7 - k); end
    end
    total++; if (rdy !== 5'b00000) begin bad++; $display("FAIL rr_ready_empty got=%b exp=00000", rdy); end
    total++; if (svc !== 5'b11111) begin bad++; $display("FAIL rr_svc got=%b exp=11111", svc); end
    tick();
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL rr_no_gnt_empty got=%b exp=00000", gnt); end
    total++; if (fc !== 4'd0)      begin bad++; $display("FAIL rr_still_empty got=%0d exp=0", fc); end
    req = 5'b0;
  endtask

  task automatic test_port_cap();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 5'b00100;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (gnt !== 5'b00100)  begin bad++; $display("FAIL cap_gnt[%0d] got=%b exp=00100", k, gnt); end
      total++; if (fc !== 4'(7 - k))  begin bad++; $display("FAIL cap_free[%0d] got=%0d exp=%0d", k, fc, 7 - k); end
    end
    total++; if (rdy !== 5'b11011) begin bad++; $display("FAIL cap_ready got=%b exp=11011", rdy); end
    total++; if (svc !== 5'b00100) begin bad++; $display("FAIL cap_svc got=%b exp=00100", svc); end
    tick();
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL cap_no_5th got=%b exp=00000", gnt); end
    total++; if (fc !== 4'd4)      begin bad++; $display("FAIL cap_free_hold got=%0d exp=4", fc); end
    req = 5'b0;
  endtask

  task automatic test_return_when_empty();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 5'b11111;
    for (int k = 0; k < 8; k++) tick();
    // holdings now p0=2 p1=2 p2=2 p3=1 p4=1, pool empty
    req = 5'b00100; cred = 5'b01001;
    tick();
    total++; if (fc !== 4'd2)      begin bad++; $display("FAIL ret_free got=%0d exp=2", fc); end
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL ret_same_cycle_gnt got=%b exp=00000", gnt); end
    total++; if (svc !== 5'b10111) begin bad++; $display("FAIL ret_svc got=%b exp=10111", svc); end
    total++; if (rdy !== 5'b11111) begin bad++; $display("FAIL ret_ready got=%b exp=11111", rdy); end
    cred = 5'b0;
    tick();
    total++; if (gnt !== 5'b00100) begin bad++; $display("FAIL ret_next_gnt got=%b exp=00100", gnt); end
    total++; if (fc !== 4'd1)      begin bad++; $display("FAIL ret_free2 got=%0d exp=1", fc); end
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL ret_err got=%b exp=0", err); end
    req = 5'b0;
  endtask

  task automatic test_same_port_grant_return();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 5'b00010;
    tick();
    total++; if (fc !== 4'd7) begin bad++; $display("FAIL sp_first_free got=%0d exp=7", fc); end
    cred = 5'b00010;
    tick();
    total++; if (gnt !== 5'b00010) begin bad++; $display("FAIL sp_gnt got=%b exp=00010", gnt); end
    total++; if (fc !== 4'd7)      begin bad++; $display("FAIL sp_free got=%0d exp=7", fc); end
    req = 5'b0; cred = 5'b0;
    tick();
    total++; if (svc !== 5'b00010) begin bad++; $display("FAIL sp_svc got=%b exp=00010", svc); end
    cred = 5'b00010;
    tick();
    // one return empties port 1, proving it held exactly one credit
    total++; if (fc !== 4'd8)      begin bad++; $display("FAIL sp_drain_free got=%0d exp=8", fc); end
    total++; if (svc !== 5'b00000) begin bad++; $display("FAIL sp_drain_svc got=%b exp=00000", svc); end
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL sp_err got=%b exp=0", err); end
    cred = 5'b0;
  endtask

  task automatic test_invalid_return();
    rst = 1'b1; tick(); rst = 1'b0;
    cred = 5'b10000;
    tick();
    total++; if (err !== 1'b1)     begin bad++; $display("FAIL inv_err got=%b exp=1", err); end
    total++; if (fc !== 4'd8)      begin bad++; $display("FAIL inv_free got=%0d exp=8", fc); end
    total++; if (svc !== 5'b00000) begin bad++; $display("FAIL inv_svc got=%b exp=00000", svc); end
    cred = 5'b0; req = 5'b00001;
    tick();
    total++; if (err !== 1'b1)     begin bad++; $display("FAIL inv_sticky got=%b exp=1", err); end
    total++; if (gnt !== 5'b00001) begin bad++; $display("FAIL inv_gnt got=%b exp=00001", gnt); end
    total++; if (fc !== 4'd7)      begin bad++; $display("FAIL inv_count got=%0d exp=7", fc); end
    req = 5'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL inv_clear got=%b exp=0", err); end
  endtask

  task automatic test_fixed_priority();
    fp_rst = 1'b1; fp_req = 5'b0; fp_cred = 5'b0;
    tick(); fp_rst = 1'b0;
    fp_req = 5'b01010;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 4) begin
        total++; if (fp_gnt !== 5'b00010) begin bad++; $display("FAIL fp_gnt[%0d] got=%b exp=00010", k, fp_gnt); end
      end else begin
        total++; if (fp_gnt !== 5'b01000) begin bad++; $display("FAIL fp_gnt[%0d] got=%b exp=01000", k, fp_gnt); end
      end
      total++; if (fp_fc !== 4'(7 - k)) begin bad++; $display("FAIL fp_free[%0d] got=%0d exp=%0d", k, fp_fc, 7 - k); end
    end
    total++; if (fp_rdy !== 5'b11101) begin bad++; $display("FAIL fp_ready got=%b exp=11101", fp_rdy); end
    fp_rst = 1'b1; fp_cred = 5'b00010;
    tick();
    total++; if (fp_gnt !== 5'b00000) begin bad++; $display("FAIL fp_rst_gnt got=%b exp=00000", fp_gnt); end
    total++; if (fp_fc !== 4'd8)      begin bad++; $display("FAIL fp_rst_free got=%0d exp=8", fp_fc); end
    total++; if (fp_rdy !== 5'b11111) begin bad++; $display("FAIL fp_rst_ready got=%b exp=11111", fp_rdy); end
    total++; if (fp_svc !== 5'b00000) begin bad++; $display("FAIL fp_rst_svc got=%b exp=00000", fp_svc); end
    total++; if (fp_err !== 1'b0)     begin bad++; $display("FAIL fp_rst_err got=%b exp=0", fp_err); end
    fp_rst = 1'b0; fp_cred = 5'b0;
    tick();
    total++; if (fp_gnt !== 5'b00010) begin bad++; $display("FAIL fp_post_rst_gnt got=%b exp=00010", fp_gnt); end
    total++; if (fp_fc !== 4'd7)      begin bad++; $display("FAIL fp_post_rst_free got=%0d exp=7", fp_fc); end
    fp_req = 5'b0;
  endtask

  initial begin
    rst = 1'b1; req = 5'b0; cred = 5'b0;
    fp_rst = 1'b1; fp_req = 5'b0; fp_cred = 5'b0;
    test_reset();
    test_round_robin();
    test_port_cap();
    test_return_when_empty();
    test_same_port_grant_return();
    test_invalid_return();
    test_fixed_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
